// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: register address width, regfile select code and
// scoreboard entry layout {valid, dst, is_load} (is_load in bit 0).
package pipeline_pkg;

    localparam int ADDR_W          = 5;
    localparam int FWD_SEL_REGFILE = 0;
    localparam int SB_LOAD_BIT     = 0;
    localparam int SB_DST_LSB      = 1;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] dst;
        logic              is_load;
    } sb_entry_t;

    function automatic int sb_entry_w(input int addr_w);
        return addr_w + 2;
    endfunction

endpackage

// File: rtl/fwd_src_match.sv
// Per-source scoreboard search: youngest in-flight writer of the source selects
// its pipeline register; flags a load that is not yet forwardable.
module fwd_src_match
    import pipeline_pkg::*;
#(
    parameter int ADDR_W     = pipeline_pkg::ADDR_W,
    parameter int DEPTH      = 2,
    parameter int LOAD_STAGE = 2,
    parameter int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic [ADDR_W-1:0]                       src_addr,
    input  logic                                    src_used,
    input  logic [DEPTH*sb_entry_w(ADDR_W)-1:0]     sb_flat,
    output logic [SEL_W-1:0]                        sel,
    output logic                                    load_hazard
);

    localparam int EW = sb_entry_w(ADDR_W);

    always_comb begin
        sel         = SEL_W'(FWD_SEL_REGFILE);
        load_hazard = 1'b0;
        // Oldest first so the youngest match is the one left standing.
        for (int j = DEPTH - 1; j >= 0; j--) begin
            if (src_used && (src_addr != '0) && sb_flat[j*EW + ADDR_W + 1] &&
                (sb_flat[j*EW + SB_DST_LSB +: ADDR_W] == src_addr)) begin
                sel         = SEL_W'(j + 1);
                load_hazard = sb_flat[j*EW + SB_LOAD_BIT] && ((j + 1) < LOAD_STAGE);
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard_unit.sv
// Forwarding/hazard unit: destination-tag scoreboard, ID-stage select resolution
// registered into EX, load-use stall. Optional counters under HAZARD_STATS_EN.
module fwd_scoreboard_unit
    import pipeline_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int ADDR_W     = pipeline_pkg::ADDR_W,
    parameter int DEPTH      = 2,
    parameter int LOAD_STAGE = 2,
    localparam int SEL_W     = $clog2(DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        id_valid,
    input  logic [NUM_SRC*ADDR_W-1:0]   id_src_addr,
    input  logic [NUM_SRC-1:0]          id_src_used,
    input  logic [ADDR_W-1:0]           id_dst_addr,
    input  logic                        id_reg_write,
    input  logic                        id_is_load,
    input  logic                        flush,
    output logic                        stall,
`ifdef HAZARD_STATS_EN
    output logic [15:0]                 stat_stall_cnt,
    output logic [15:0]                 stat_fwd_cnt,
`endif
    output logic [NUM_SRC*SEL_W-1:0]    ex_fwd_sel
);

    localparam int EW = sb_entry_w(ADDR_W);

    logic [DEPTH*EW-1:0]        sb_q, sb_d;
    logic [NUM_SRC*SEL_W-1:0]   sel_all;
    logic [NUM_SRC*SEL_W-1:0]   ex_fwd_sel_q, ex_fwd_sel_d;
    logic [NUM_SRC-1:0]         hazard;
    logic [EW-1:0]              new_entry;
    logic                       bubble;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_src_match #(
            .ADDR_W     (ADDR_W),
            .DEPTH      (DEPTH),
            .LOAD_STAGE (LOAD_STAGE),
            .SEL_W      (SEL_W)
        ) u_match (
            .src_addr    (id_src_addr[i*ADDR_W +: ADDR_W]),
            .src_used    (id_src_used[i]),
            .sb_flat     (sb_q),
            .sel         (sel_all[i*SEL_W +: SEL_W]),
            .load_hazard (hazard[i])
        );
    end

    always_comb begin
        // Flush and reset both override a pending load-use hazard.
        stall     = id_valid & ~flush & ~reset & (|hazard);
        bubble    = stall | flush | ~id_valid;
        new_entry = '0;
        if (!bubble) begin
            new_entry = {id_reg_write && (id_dst_addr != '0), id_dst_addr, id_is_load};
        end
        sb_d = sb_q;
        for (int k = DEPTH - 1; k >= 1; k--) begin
            sb_d[k*EW +: EW] = sb_q[(k-1)*EW +: EW];
        end
        sb_d[EW-1:0] = new_entry;
        ex_fwd_sel_d = bubble ? '0 : sel_all;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sb_q         <= '0;
            ex_fwd_sel_q <= '0;
        end else begin
            sb_q         <= sb_d;
            ex_fwd_sel_q <= ex_fwd_sel_d;
        end
    end

    assign ex_fwd_sel = ex_fwd_sel_q;

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] fwd_cnt_q, fwd_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (!bubble && (|sel_all) && (fwd_cnt_q != 16'hFFFF)) begin
            fwd_cnt_d = fwd_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign stat_stall_cnt = stall_cnt_q;
    assign stat_fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_scoreboard_unit.sv
// Bench for fwd_scoreboard_unit: directed hazard scenarios plus random traffic,
// all checked every cycle against a queue-based model of in-flight writers.
module tb_fwd_scoreboard_unit;

    localparam int NUM_SRC    = 2;
    localparam int ADDR_W     = 5;
    localparam int DEPTH      = 2;
    localparam int LOAD_STAGE = 2;
    localparam int SEL_W      = 2;

    logic                       clk = 1'b0;
    logic                       reset = 1'b1;
    logic                       id_valid = 1'b0;
    logic [NUM_SRC*ADDR_W-1:0]  id_src_addr = '0;
    logic [NUM_SRC-1:0]         id_src_used = '0;
    logic [ADDR_W-1:0]          id_dst_addr = '0;
    logic                       id_reg_write = 1'b0;
    logic                       id_is_load = 1'b0;
    logic                       flush = 1'b0;
    logic                       stall;
    logic [NUM_SRC*SEL_W-1:0]   ex_fwd_sel;
`ifdef HAZARD_STATS_EN
    logic [15:0]                stat_stall_cnt, stat_fwd_cnt;
`endif

    fwd_scoreboard_unit #(
        .NUM_SRC    (NUM_SRC),
        .ADDR_W     (ADDR_W),
        .DEPTH      (DEPTH),
        .LOAD_STAGE (LOAD_STAGE)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .id_valid       (id_valid),
        .id_src_addr    (id_src_addr),
        .id_src_used    (id_src_used),
        .id_dst_addr    (id_dst_addr),
        .id_reg_write   (id_reg_write),
        .id_is_load     (id_is_load),
        .flush          (flush),
        .stall          (stall),
`ifdef HAZARD_STATS_EN
        .stat_stall_cnt (stat_stall_cnt),
        .stat_fwd_cnt   (stat_fwd_cnt),
`endif
        .ex_fwd_sel     (ex_fwd_sel)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // inflight[0] is the instruction now in EX, inflight[k] the one in register k.
    typedef struct {
        bit v;
        int dst;
        bit ld;
    } rec_t;

    rec_t                       inflight[$];
    logic [NUM_SRC*SEL_W-1:0]   exp_sel_q = '0;
    int                         exp_stall_cnt = 0;
    int                         exp_fwd_cnt = 0;

    function automatic int youngest_writer(input int src, input bit used, output bit hz);
        hz = 1'b0;
        if (!used || src == 0) return 0;
        for (int j = 0; j < inflight.size(); j++) begin
            if (inflight[j].v && inflight[j].dst == src) begin
                hz = inflight[j].ld && (j + 1 < LOAD_STAGE);
                return j + 1;
            end
        end
        return 0;
    endfunction

    function automatic bit model_selects(output logic [NUM_SRC*SEL_W-1:0] sv);
        bit any_hz = 1'b0;
        bit hz;
        int s;
        sv = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            s = youngest_writer(int'(id_src_addr[i*ADDR_W +: ADDR_W]), id_src_used[i], hz);
            sv[i*SEL_W +: SEL_W] = SEL_W'(s);
            any_hz |= hz;
        end
        return any_hz;
    endfunction

    function automatic bit model_stall();
        logic [NUM_SRC*SEL_W-1:0] sv;
        bit hz_any;
        hz_any = model_selects(sv);
        return !reset && id_valid && !flush && hz_any;
    endfunction

    always @(posedge clk) begin
        logic [NUM_SRC*SEL_W-1:0] sv;
        bit   st, bub;
        rec_t r;
        if (reset) begin
            foreach (inflight[k]) inflight[k].v = 1'b0;
            exp_sel_q     = '0;
            exp_stall_cnt = 0;
            exp_fwd_cnt   = 0;
        end else begin
            void'(model_selects(sv));
            st  = model_stall();
            bub = st || flush || !id_valid;
            r.v   = !bub && id_reg_write && (id_dst_addr != 0);
            r.dst = int'(id_dst_addr);
            r.ld  = id_is_load;
            inflight.push_front(r);
            void'(inflight.pop_back());
            exp_sel_q = bub ? '0 : sv;
            if (st && exp_stall_cnt < 65535) exp_stall_cnt++;
            if (!bub && (sv != '0) && exp_fwd_cnt < 65535) exp_fwd_cnt++;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        check("stall", {31'd0, stall}, {31'd0, model_stall()});
        check("ex_fwd_sel", 32'(ex_fwd_sel), 32'(exp_sel_q));
`ifdef HAZARD_STATS_EN
        check("stat_stall_cnt", 32'(stat_stall_cnt), 32'(exp_stall_cnt));
        check("stat_fwd_cnt", 32'(stat_fwd_cnt), 32'(exp_fwd_cnt));
`endif
    end

    // ---------------- driver tasks ----------------
    task automatic set_in(input bit v, input int s0, input int s1, input bit u0, input bit u1,
                          input int dst, input bit rw, input bit ld, input bit fl);
        id_valid     = v;
        id_src_addr  = {ADDR_W'(s1), ADDR_W'(s0)};
        id_src_used  = {u1, u0};
        id_dst_addr  = ADDR_W'(dst);
        id_reg_write = rw;
        id_is_load   = ld;
        flush        = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int s0, input int s1, input bit u0, input bit u1,
                         input int dst, input bit rw, input bit ld);
        set_in(1'b1, s0, s1, u0, u1, dst, rw, ld, 1'b0);
        tick();
    endtask

    task automatic idle(input int n);
        set_in(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        repeat (n) tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int k = 0; k < DEPTH; k++) inflight.push_back('{v: 1'b0, dst: 0, ld: 1'b0});
        reset = 1'b1;
        idle(3);
        check("reset_sel", 32'(ex_fwd_sel), 32'd0);
        check("reset_stall", {31'd0, stall}, 32'd0);
        reset = 1'b0;
        idle(1);

        // EX/MEM forward of a plain ALU result
        issue(1, 2, 1'b1, 1'b1, 3, 1'b1, 1'b0);
        issue(3, 2, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        check("exmem_fwd", 32'(ex_fwd_sel), 32'h1);
        idle(2);

        // youngest writer of r5 wins on both sources
        issue(1, 1, 1'b0, 1'b0, 5, 1'b1, 1'b0);
        issue(1, 1, 1'b0, 1'b0, 5, 1'b1, 1'b0);
        issue(5, 5, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        check("priority", 32'(ex_fwd_sel), 32'h5);
        idle(2);

        // load-use: one bubble, then forward from MEM/WB
        issue(1, 1, 1'b0, 1'b0, 4, 1'b1, 1'b1);
        set_in(1'b1, 4, 1, 1'b1, 1'b1, 6, 1'b1, 1'b0, 1'b0);
        #1 check("lu_stall", {31'd0, stall}, 32'd1);
        tick();
        check("lu_bubble_sel", 32'(ex_fwd_sel), 32'h0);
        check("lu_stall_clear", {31'd0, stall}, 32'd0);
        tick();
        check("lu_fwd_sel", 32'(ex_fwd_sel), 32'h2);
        idle(2);

        // r0 never forwards; unused sources never forward or stall
        issue(1, 1, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        issue(0, 0, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        check("r0_sel", 32'(ex_fwd_sel), 32'h0);
        issue(1, 1, 1'b0, 1'b0, 6, 1'b1, 1'b0);
        issue(6, 6, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        check("unused_sel", 32'(ex_fwd_sel), 32'h0);
        issue(1, 1, 1'b0, 1'b0, 7, 1'b1, 1'b1);
        set_in(1'b1, 7, 7, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        #1 check("unused_no_stall", {31'd0, stall}, 32'd0);
        idle(2);

        // flush beats a pending load-use stall
        issue(1, 1, 1'b0, 1'b0, 8, 1'b1, 1'b1);
        set_in(1'b1, 8, 0, 1'b1, 1'b0, 9, 1'b1, 1'b0, 1'b1);
        #1 check("flush_stall", {31'd0, stall}, 32'd0);
        tick();
        check("flush_sel", 32'(ex_fwd_sel), 32'h0);
        idle(3);

        // reset mid-stream discards in-flight tags
        issue(1, 1, 1'b0, 1'b0, 9, 1'b1, 1'b0);
        issue(1, 1, 1'b0, 1'b0, 10, 1'b1, 1'b1);
        reset = 1'b1;
        set_in(1'b1, 10, 9, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        #1 check("reset_blocks_stall", {31'd0, stall}, 32'd0);
        tick();
        reset = 1'b0;
        check("reset_mid_sel", 32'(ex_fwd_sel), 32'h0);
`ifdef HAZARD_STATS_EN
        check("reset_stat_stall", 32'(stat_stall_cnt), 32'd0);
        check("reset_stat_fwd", 32'(stat_fwd_cnt), 32'd0);
`endif
        issue(9, 10, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        check("reset_old_dst", 32'(ex_fwd_sel), 32'h0);
        idle(2);

        // random traffic over a small register range to force frequent matches
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 199) == 0);
            set_in($urandom_range(0, 3) != 0,
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                   int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
            tick();
        end
        reset = 1'b0;
        idle(3);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
